// File: rtl/lfsr_rng_pkg.sv
// lfsr_rng_pkg: shared encodings and generator step for lfsr_rng_arbiter.
`default_nettype none

package lfsr_rng_pkg;

  localparam int LEN_W = 3;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SERVE  = 2'd1;
  localparam logic [1:0] RESEED = 2'd2;

  // Low bits fold in freshly computed high bits, so the order below matters.
  function automatic logic [4:0] lfsr_next(input logic [4:0] r);
    logic [4:0] n;
    n[4] = r[4] ^ r[1];
    n[3] = r[3] ^ r[0];
    n[2] = r[2] ^ n[4];
    n[1] = r[1] ^ n[3];
    n[0] = r[0] ^ n[2];
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after rr_ptr.
`default_nettype none

module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] rr_ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] id,
  output logic            any_req
);

  logic [ID_W-1:0] cand;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    return ID_W'(sum);
  endfunction

  always_comb begin
    gnt     = '0;
    id      = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = wrap_idx(rr_ptr, i);
      if (!any_req && req[cand]) begin
        any_req   = 1'b1;
        id        = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/lfsr_rng_arbiter.sv
// lfsr_rng_arbiter: one 5-bit generator shared round-robin among NREQ requesters,
// delivering 1-8 word bursts, with deferred reseed between bursts.
`default_nettype none

module lfsr_rng_arbiter
  import lfsr_rng_pkg::*;
#(
  parameter int         NREQ = 4,
  parameter logic [4:0] SEED = 5'h03
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NREQ-1:0]           i_req,
  input  logic [LEN_W*NREQ-1:0]     i_len,
  input  logic                      i_reseed,
  input  logic [4:0]                i_seed,
  output logic [NREQ-1:0]           o_gnt,
  output logic [$clog2(NREQ)-1:0]   o_id,
  output logic                      o_valid,
  output logic [4:0]                o_data,
  output logic                      o_last,
  output logic                      o_busy
);

  localparam int ID_W = $clog2(NREQ);

  logic [1:0]       state, nxt_state;
  logic [LEN_W-1:0] cnt, nxt_cnt;
  logic [4:0]       gen, nxt_gen;
  logic             pend_reseed, nxt_pend;
  logic [4:0]       pend_seed, nxt_pend_seed;
  logic [ID_W-1:0]  rr_ptr, nxt_ptr;
  logic [NREQ-1:0]  nxt_gnt, arb_gnt;
  logic [ID_W-1:0]  nxt_id, arb_id;
  logic             arb_any;
  logic             decide;
  logic             reseed_now;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req     (i_req),
    .rr_ptr  (rr_ptr),
    .gnt     (arb_gnt),
    .id      (arb_id),
    .any_req (arb_any)
  );

  assign decide     = (state == IDLE) || ((state == SERVE) && (cnt == '0));
  assign reseed_now = pend_reseed | i_reseed;

  always_comb begin
    nxt_state     = state;
    nxt_cnt       = cnt;
    nxt_gen       = gen;
    nxt_ptr       = rr_ptr;
    nxt_gnt       = o_gnt;
    nxt_id        = o_id;
    nxt_pend      = pend_reseed | i_reseed;
    nxt_pend_seed = i_reseed ? i_seed : pend_seed;

    // Generator moves only on delivered words, so each grantee gets a disjoint slice.
    if (state == SERVE) begin
      nxt_gen = lfsr_next(gen);
      nxt_cnt = cnt - LEN_W'(1);
    end else if (state == RESEED) begin
      nxt_gen = (pend_seed == '0) ? SEED : pend_seed;
    end

    if (state == RESEED) begin
      nxt_state = IDLE;
      nxt_gnt   = '0;
      nxt_cnt   = '0;
    end else if (decide) begin
      if (reseed_now) begin
        nxt_state = RESEED;
        nxt_pend  = 1'b0;
        nxt_gnt   = '0;
        nxt_cnt   = '0;
      end else if (arb_any) begin
        nxt_state = SERVE;
        nxt_cnt   = i_len[int'(arb_id)*LEN_W +: LEN_W];
        nxt_gnt   = arb_gnt;
        nxt_id    = arb_id;
        nxt_ptr   = (arb_id == ID_W'(NREQ - 1)) ? '0 : arb_id + ID_W'(1);
      end else begin
        nxt_state = IDLE;
        nxt_gnt   = '0;
        nxt_cnt   = '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      cnt         <= '0;
      gen         <= SEED;
      pend_reseed <= 1'b0;
      pend_seed   <= '0;
      rr_ptr      <= '0;
      o_gnt       <= '0;
      o_id        <= '0;
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_last      <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      gen         <= nxt_gen;
      pend_reseed <= nxt_pend;
      pend_seed   <= nxt_pend_seed;
      rr_ptr      <= nxt_ptr;
      o_gnt       <= nxt_gnt;
      o_id        <= nxt_id;
      o_valid     <= (nxt_state == SERVE);
      o_data      <= (nxt_state == SERVE) ? nxt_gen : '0;
      o_last      <= (nxt_state == SERVE) && (nxt_cnt == '0);
      o_busy      <= (nxt_state != IDLE);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lfsr_rng_arbiter.sv
// tb_lfsr_rng_arbiter: directed scenarios plus randomized traffic against a burst-level model.
`default_nettype none

module tb_lfsr_rng_arbiter;

  localparam int NREQ = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NREQ-1:0]  req;
  logic [3*NREQ-1:0] len;
  logic             reseed;
  logic [4:0]       seed;
  logic [NREQ-1:0]  gnt;
  logic [1:0]       id;
  logic             valid;
  logic [4:0]       data;
  logic             last;
  logic             busy;

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 idle, 1 delivering a burst, 2 reseeding.
  logic [4:0] m_gen;
  int         m_phase;
  int         m_left;
  int         m_owner;
  int         m_ptr;
  bit         m_pend;
  logic [4:0] m_pseed;
  logic [4:0] m_rseed;

  always #5 clk = ~clk;

  lfsr_rng_arbiter #(
    .NREQ (NREQ),
    .SEED (5'h03)
  ) dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_req    (req),
    .i_len    (len),
    .i_reseed (reseed),
    .i_seed   (seed),
    .o_gnt    (gnt),
    .o_id     (id),
    .o_valid  (valid),
    .o_data   (data),
    .o_last   (last),
    .o_busy   (busy)
  );

  function automatic logic [4:0] ref_next(input logic [4:0] r);
    logic [4:0] n;
    n[4] = r[4] ^ r[1];
    n[3] = r[3] ^ r[0];
    n[2] = r[2] ^ n[4];
    n[1] = r[1] ^ n[3];
    n[0] = r[0] ^ n[2];
    return n;
  endfunction

  task automatic model_edge();
    bit decision;
    decision = (m_phase == 0) || (m_phase == 1 && m_left == 1);
    if (rst) begin
      m_gen = 5'h03; m_phase = 0; m_left = 0; m_owner = 0;
      m_ptr = 0; m_pend = 0; m_pseed = '0; m_rseed = '0;
      return;
    end
    if (m_phase == 1) begin
      m_gen = ref_next(m_gen);
      m_left--;
    end else if (m_phase == 2) begin
      m_gen   = (m_rseed == 0) ? 5'h03 : m_rseed;
      m_phase = 0;
    end
    if (reseed) begin
      m_pend  = 1;
      m_pseed = seed;
    end
    if (decision) begin
      if (m_pend) begin
        m_phase = 2; m_rseed = m_pseed; m_pend = 0;
      end else if (req != 0) begin
        for (int k = 0; k < NREQ; k++) begin
          if (req[(m_ptr + k) % NREQ]) begin
            m_owner = (m_ptr + k) % NREQ;
            break;
          end
        end
        m_left  = int'(len[3*m_owner +: 3]) + 1;
        m_ptr   = (m_owner + 1) % NREQ;
        m_phase = 1;
      end else begin
        m_phase = 0;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    req = '0; reseed = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (!busy && !valid) begin
        done = 1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout busy=%b valid=%b required idle within 20 cycles", busy, valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; len = '0; reseed = 1'b0; seed = '0;
    tick(); tick();
    checks++;
    if ({gnt, valid, data, last, busy, id} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b valid=%b data=%h last=%b busy=%b id=%0d required all 0",
               gnt, valid, data, last, busy, id);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b valid=%b required 0 0", busy, valid);
    end
  endtask

  task automatic test_single();
    logic [4:0] exp_w [4] = '{5'h03, 5'h1C, 5'h1A, 5'h08};
    req = 4'b0001; len = 12'h002;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (!(valid === 1'b1 && data === exp_w[c] && id === 2'd0)) begin
        errors++;
        $display("FAIL single_word%0d got valid=%b data=%h id=%0d required 1 %h 0",
                 c, valid, data, id, exp_w[c]);
      end
      checks++;
      if (last !== (c == 2)) begin
        errors++;
        $display("FAIL single_last%0d got %b required %b", c, last, (c == 2));
      end
    end
    drain();
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_w [5] = '{5'h03, 5'h1C, 5'h1A, 5'h08, 5'h0A};
    logic [1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111; len = 12'h000;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (!(valid === 1'b1 && last === 1'b1 && id === exp_id[c] && data === exp_w[c])) begin
        errors++;
        $display("FAIL rr_word%0d got valid=%b last=%b id=%0d data=%h required 1 1 %0d %h",
                 c, valid, last, id, data, exp_id[c], exp_w[c]);
      end
    end
    drain();
  endtask

  task automatic test_mid_drop();
    int words;
    int last_at;
    words = 0; last_at = 0;
    req = 4'b0100; len = 12'h1C0;
    tick();
    checks++;
    if (!(gnt === 4'b0100 && id === 2'd2 && valid === 1'b1)) begin
      errors++;
      $display("FAIL drop_grant got gnt=%b id=%0d valid=%b required 0100 2 1", gnt, id, valid);
    end
    if (valid) words++;
    tick();
    if (valid) words++;
    req = '0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (!valid) break;
      words++;
      if (last) last_at = words;
      checks++;
      if (data !== m_gen) begin
        errors++;
        $display("FAIL drop_data got %h required %h", data, m_gen);
      end
    end
    checks++;
    if (words != 8 || last_at != 8) begin
      errors++;
      $display("FAIL drop_words got words=%0d last_at=%0d required 8 8", words, last_at);
    end
    checks++;
    if (gnt !== '0) begin
      errors++;
      $display("FAIL drop_gnt_clear got %b required 0000", gnt);
    end
  endtask

  task automatic test_reseed_defer();
    int words;
    words = 0;
    req = 4'b0001; len = 12'h003;
    tick();
    if (valid) words++;
    reseed = 1'b1; seed = 5'h11; req = '0;
    tick();
    if (valid) words++;
    reseed = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (valid) words++;
      else break;
    end
    checks++;
    if (words != 4) begin
      errors++;
      $display("FAIL defer_words got %0d required 4", words);
    end
    checks++;
    if (!(busy === 1'b1 && valid === 1'b0 && data === 5'h00)) begin
      errors++;
      $display("FAIL defer_reseed_cycle got busy=%b valid=%b data=%h required 1 0 00", busy, valid, data);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL defer_idle got busy=%b required 0", busy);
    end
    req = 4'b0001; len = 12'h000;
    tick();
    checks++;
    if (!(valid === 1'b1 && data === 5'h11)) begin
      errors++;
      $display("FAIL defer_first_word got valid=%b data=%h required 1 11", valid, data);
    end
    drain();
  endtask

  task automatic test_zero_seed();
    reseed = 1'b1; seed = 5'h00; req = 4'b0001; len = 12'h000;
    tick();
    reseed = 1'b0;
    checks++;
    if (!(busy === 1'b1 && valid === 1'b0)) begin
      errors++;
      $display("FAIL zero_reseed_first got busy=%b valid=%b required 1 0", busy, valid);
    end
    tick();
    checks++;
    if (!(busy === 1'b0 && valid === 1'b0)) begin
      errors++;
      $display("FAIL zero_idle got busy=%b valid=%b required 0 0", busy, valid);
    end
    tick();
    checks++;
    if (!(valid === 1'b1 && data === 5'h03 && gnt === 4'b0001)) begin
      errors++;
      $display("FAIL zero_word got valid=%b data=%h gnt=%b required 1 03 0001", valid, data, gnt);
    end
    drain();
  endtask

  task automatic test_reset_mid_burst();
    req = 4'b0001; len = 12'h007;
    tick(); tick(); tick();
    checks++;
    if (!(valid === 1'b1 && last === 1'b0)) begin
      errors++;
      $display("FAIL rmb_word3 got valid=%b last=%b required 1 0", valid, last);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({gnt, valid, data, last, busy, id} !== '0) begin
      errors++;
      $display("FAIL rmb_outputs got gnt=%b valid=%b data=%h last=%b busy=%b id=%0d required all 0",
               gnt, valid, data, last, busy, id);
    end
    rst = 1'b0; req = 4'b0010; len = 12'h000;
    tick();
    checks++;
    if (!(valid === 1'b1 && data === 5'h03 && id === 2'd1)) begin
      errors++;
      $display("FAIL rmb_restart got valid=%b data=%h id=%0d required 1 03 1", valid, data, id);
    end
    drain();
  endtask

  task automatic test_random();
    logic [NREQ+7:0] got_v;
    logic [NREQ+7:0] exp_v;
    logic [NREQ-1:0] e_gnt;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      req    = ($urandom_range(0, 3) == 0) ? '0 : 4'($urandom_range(0, 15));
      len    = 12'($urandom);
      reseed = ($urandom_range(0, 15) == 0);
      seed   = ($urandom_range(0, 3) == 0) ? 5'h00 : 5'($urandom);
      tick();
      e_gnt = (m_phase == 1) ? (4'd1 << m_owner) : 4'd0;
      exp_v = {e_gnt, (m_phase == 1), ((m_phase == 1) ? m_gen : 5'h00),
               (m_phase == 1 && m_left == 1), (m_phase != 0)};
      got_v = {gnt, valid, data, last, busy};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL rand_cycle%0d got {gnt,valid,data,last,busy}=%h required %h", c, got_v, exp_v);
      end
      if (m_phase == 1) begin
        checks++;
        if (id !== 2'(m_owner)) begin
          errors++;
          $display("FAIL rand_id%0d got %0d required %0d", c, id, m_owner);
        end
      end
    end
    reseed = 1'b0;
    drain();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_mid_drop();
    test_reseed_defer();
    test_zero_seed();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lfsr_rng_arbiter.md
# lfsr_rng_arbiter

Shares one 5-bit pseudo-random generator between NREQ requesters (shader lanes, dither and noise units) in the GPU pixel pipeline. Grants are round-robin, and each grant delivers a burst of 1–8 consecutive generator words. The generator advances only on delivered words, so every requester sees a disjoint sub-sequence. A reseed port lets the command processor restart the sequence between bursts.

## Interface
- NREQ, 4, number of requesters (2..8)
- SEED, 5'h03, generator value after reset and on a zero reseed
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_req  in  NREQ  per-requester request level
- i_len  in  3*NREQ  burst length field per requester; L means L+1 words; sampled only at grant
- i_reseed  in  1  reseed request, single-cycle pulse
- i_seed  in  5  seed value, sampled with i_reseed
- o_gnt  out  NREQ  one-hot grant, held for the whole burst
- o_id  out  $clog2(NREQ)  index of the current grantee
- o_valid  out  1  o_data is valid this cycle
- o_data  out  5  generator word
- o_last  out  1  final word of the burst
- o_busy  out  1  burst or reseed in progress

## Operation
- Generator next-state, where r is the current value and n the next:
  - n4 = r4^r1
  - n3 = r3^r0
  - n2 = r2^n4
  - n1 = r1^n3
  - n0 = r0^n2
- From 5'h03 the sequence is 1C, 1A, 08, …
- The generator updates only on a cycle with o_valid=1 (it takes next state) or in RESEED. Otherwise it holds.
- FSM states:
  - IDLE: nothing in flight.
  - SERVE: burst counter cnt is active; the grantee is registered.
  - RESEED: one cycle; the generator loads i_seed, or SEED if i_seed==0 (all-zero is a lock-up state).
- A reseed request is latched into pend_reseed. A new pulse while one is pending overwrites the seed; the last value wins.
- Decision point: any IDLE cycle, or the o_last cycle of SERVE.
  - If pend_reseed is set, go to RESEED; it has priority over all requests.
  - Else if any i_req bit is set, pick the first set bit at or after rr_ptr (circular), go to SERVE, load cnt=i_len[id], register the grant.
  - Else go to IDLE.
- After a grant, rr_ptr = id+1 (mod NREQ).
- RESEED always returns to IDLE.
- In SERVE:
  - o_valid=1 and o_data = generator value.
  - cnt decrements each cycle; o_last=1 when cnt==0.
- Once granted, a burst completes even if i_req drops. The requester must ignore words it no longer wants.
- i_reseed arriving mid-burst is deferred: the burst finishes, then RESEED runs.
- Reset values:
  - o_gnt=0, o_valid=0, o_last=0, o_busy=0, o_id=0, o_data=0
  - rr_ptr=0, cnt=0, pend_reseed=0
  - generator=SEED, state=IDLE
- o_data is forced to 0 whenever o_valid=0.
- Reset asserted mid-burst aborts immediately; no o_last is produced.

## Timing
- All outputs are registered.
- Request to first word: i_req high at edge k means o_gnt/o_valid high in cycle k+1 (1-cycle latency from IDLE).
- Back-to-back bursts have no bubble. If a request is pending at the o_last cycle, the next grantee's first word is in the following cycle.
- A burst of L+1 words holds o_gnt for exactly L+1 consecutive cycles.
- Reseed: pulse at edge k in IDLE gives RESEED in cycle k+1 (o_busy=1, o_valid=0) and IDLE in k+2. The first word after reseed is the new seed value.
- A simultaneous i_reseed and i_req at an IDLE decision gives RESEED first; the request is granted at the decision after RESEED.
- o_busy=1 in SERVE and RESEED, 0 in IDLE.

## Structure
- Package lfsr_rng_pkg holds:
  - state encoding: IDLE=2'd0, SERVE=2'd1, RESEED=2'd2
  - the generator next-state function
  - constant LEN_W=3
- Sub-module rr_arbiter (NREQ): combinational. Inputs are req and rr_ptr; outputs are a one-hot grant, the index, and any_req. It is reused by other shared units.
- The top level owns the FSM, cnt, pend_reseed and the generator register.

## Test plan
- Single requester: reset; i_req=0001, i_len[0]=2 → cycles 1–3 deliver o_data 03, 1C, 1A with o_id=0, o_last in cycle 3; the next burst starts with 08.
- Round-robin: i_req=1111, all i_len=0 → o_id sequence 0,1,2,3,0 with no bubbles and successive words 03, 1C, 1A, 08, …
- Mid-burst drop: grant requester 2 with i_len=7, drop i_req after 2 cycles → all 8 words still delivered, then o_gnt=0.
- Reseed deferral: i_reseed with i_seed=5'h11 during a burst → burst finishes, one RESEED cycle (o_busy=1, o_valid=0), next burst's first word = 11.
- Zero seed: i_reseed with i_seed=0 in IDLE → next word = 03; reseed and req in the same cycle → RESEED first.
- Reset mid-burst: assert i_reset in word 3 of an 8-word burst → next cycle all outputs 0 and generator=03; the first grant after release outputs 03.
